// File: rtl/store_queue_fwd.sv
// Store queue: in-order alloc, AGU fill, in-order commit/drain, youngest-first store-to-load forwarding.
// Latency: commit, forward and stall are combinational; pointers advance on the next clock edge.
// Backpressure: alloc_ready drops when full (registered state only); drain holds its fields until dmem_ready.
module store_queue_fwd #(
  parameter int DEPTH    = 8,
  parameter int ROB_ID_W = 5,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  localparam int MASK_W  = DATA_W / 8,
  localparam int IDX_W   = $clog2(DEPTH),
  localparam int PTR_W   = IDX_W + 1
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_flush,
  input  logic                i_alloc_valid,
  output logic                o_alloc_ready,
  input  logic [ROB_ID_W-1:0] i_alloc_rob_id,
  input  logic                i_agu_valid,
  input  logic [ROB_ID_W-1:0] i_agu_rob_id,
  input  logic [ADDR_W-1:0]   i_agu_addr,
  input  logic [MASK_W-1:0]   i_agu_mask,
  input  logic [DATA_W-1:0]   i_agu_wdata,
  input  logic [ROB_ID_W-1:0] i_rob_head_id,
  output logic                o_commit_valid,
  output logic [ROB_ID_W-1:0] o_commit_rob_id,
  output logic                o_dmem_valid,
  input  logic                i_dmem_ready,
  output logic [ADDR_W-1:0]   o_dmem_addr,
  output logic [MASK_W-1:0]   o_dmem_wmask,
  output logic [DATA_W-1:0]   o_dmem_wdata,
  output logic [PTR_W-1:0]    o_tail_ptr,
  input  logic                i_ld_valid,
  input  logic [ADDR_W-1:0]   i_ld_addr,
  input  logic [MASK_W-1:0]   i_ld_mask,
  input  logic [PTR_W-1:0]    i_ld_age,
  output logic                o_ld_fwd_hit,
  output logic [DATA_W-1:0]   o_ld_fwd_data,
  output logic                o_ld_stall
);

  // Clears the byte-offset bits so two addresses can be compared at word granularity.
  localparam logic [ADDR_W-1:0] WORD_MASK = ~(ADDR_W'(MASK_W - 1));

  // Pointers carry a wrap bit: head (drain) <= cmt (commit) <= tail (alloc).
  logic [PTR_W-1:0]    r_head;
  logic [PTR_W-1:0]    r_cmt;
  logic [PTR_W-1:0]    r_tail;

  logic [DEPTH-1:0]    r_valid;
  logic [DEPTH-1:0]    r_addr_valid;
  logic [ROB_ID_W-1:0] r_rob_id [DEPTH];
  logic [ADDR_W-1:0]   r_addr   [DEPTH];
  logic [MASK_W-1:0]   r_mask   [DEPTH];
  logic [DATA_W-1:0]   r_wdata  [DEPTH];

  logic [IDX_W-1:0]    w_head_idx;
  logic [IDX_W-1:0]    w_cmt_idx;
  logic [IDX_W-1:0]    w_tail_idx;
  logic [PTR_W-1:0]    w_pend;
  logic                w_full;
  logic                w_alloc_fire;
  logic                w_commit;
  logic [PTR_W-1:0]    w_cmt_next;
  logic                w_drain_vld;
  logic                w_drain_fire;
  logic [DEPTH-1:0]    w_uncmt;
  logic [DEPTH-1:0]    w_agu_hit;
  logic [DEPTH-1:0]    w_flush_kill;

  logic                w_fwd_hit;
  logic                w_fwd_stall;
  logic [DATA_W-1:0]   w_fwd_data;
  logic                w_fwd_done;
  logic [PTR_W-1:0]    w_fwd_cnt;
  logic [IDX_W-1:0]    w_scan_idx;

  assign w_head_idx = r_head[IDX_W-1:0];
  assign w_cmt_idx  = r_cmt[IDX_W-1:0];
  assign w_tail_idx = r_tail[IDX_W-1:0];
  assign w_pend     = r_tail - r_cmt;
  assign w_full     = ((r_tail - r_head) == PTR_W'(DEPTH));

  // Flush wins over a same-cycle alloc; fullness ignores a same-cycle drain.
  assign w_alloc_fire = i_alloc_valid & ~w_full & ~i_flush;

  assign w_commit   = (r_cmt != r_tail) & r_addr_valid[w_cmt_idx] &
                      (r_rob_id[w_cmt_idx] == i_rob_head_id);
  assign w_cmt_next = r_cmt + {{(PTR_W-1){1'b0}}, w_commit};

  assign w_drain_vld  = (r_head != r_cmt);
  assign w_drain_fire = w_drain_vld & i_dmem_ready;

  // Per-entry classification: uncommitted range [cmt, tail), AGU capture and flush kill.
  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    logic [IDX_W-1:0] w_off;
    assign w_off           = IDX_W'(g) - w_cmt_idx;
    assign w_uncmt[g]      = ({1'b0, w_off} < w_pend);
    assign w_agu_hit[g]    = i_agu_valid & r_valid[g] & ~r_addr_valid[g] & w_uncmt[g] &
                             (r_rob_id[g] == i_agu_rob_id);
    // An entry committing in the flush cycle is already architecturally retired.
    assign w_flush_kill[g] = i_flush & w_uncmt[g] &
                             ~(w_commit & (w_cmt_idx == IDX_W'(g)));
  end

  assign o_alloc_ready   = ~w_full;
  assign o_commit_valid  = w_commit;
  assign o_commit_rob_id = w_commit ? r_rob_id[w_cmt_idx] : '0;
  assign o_dmem_valid    = w_drain_vld;
  assign o_dmem_addr     = w_drain_vld ? (r_addr[w_head_idx] & WORD_MASK) : '0;
  assign o_dmem_wmask    = w_drain_vld ? r_mask[w_head_idx] : '0;
  assign o_dmem_wdata    = w_drain_vld ? r_wdata[w_head_idx] : '0;
  assign o_tail_ptr      = r_tail;
  assign o_ld_fwd_hit    = w_fwd_hit;
  assign o_ld_fwd_data   = w_fwd_data;
  assign o_ld_stall      = w_fwd_stall;

  // Forwarding scan over [head, ld_age), youngest first; the first deciding entry ends it.
  always_comb begin
    w_fwd_hit   = 1'b0;
    w_fwd_stall = 1'b0;
    w_fwd_data  = '0;
    w_fwd_done  = 1'b0;
    w_fwd_cnt   = i_ld_age - r_head;
    w_scan_idx  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_scan_idx = IDX_W'(i_ld_age - PTR_W'(k + 1));
      if (i_ld_valid && !w_fwd_done && (PTR_W'(k) < w_fwd_cnt) && r_valid[w_scan_idx]) begin
        if (!r_addr_valid[w_scan_idx]) begin
          w_fwd_stall = 1'b1;
          w_fwd_done  = 1'b1;
        end else if ((((r_addr[w_scan_idx] ^ i_ld_addr) & WORD_MASK) == '0) &&
                     ((r_mask[w_scan_idx] & i_ld_mask) != '0)) begin
          w_fwd_done = 1'b1;
          if ((r_mask[w_scan_idx] & i_ld_mask) == i_ld_mask) begin
            w_fwd_hit  = 1'b1;
            w_fwd_data = r_wdata[w_scan_idx];
          end else begin
            w_fwd_stall = 1'b1;
          end
        end
      end
    end
  end

  // Pointer advance: drain moves head, commit moves cmt, flush rewinds tail to cmt_next.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_head <= '0;
      r_cmt  <= '0;
      r_tail <= '0;
    end else begin
      if (w_drain_fire) begin
        r_head <= r_head + PTR_W'(1);
      end
      if (i_flush) begin
        r_tail <= w_cmt_next;
      end else if (w_alloc_fire) begin
        r_tail <= r_tail + PTR_W'(1);
      end
      r_cmt <= w_cmt_next;
    end
  end

  // Entry status bits; later statements take priority (flush kill over AGU fill).
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid      <= '0;
      r_addr_valid <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_alloc_fire && (w_tail_idx == IDX_W'(i))) begin
          r_valid[i]      <= 1'b1;
          r_addr_valid[i] <= 1'b0;
        end
        if (w_agu_hit[i]) begin
          r_addr_valid[i] <= 1'b1;
        end
        if (w_flush_kill[i]) begin
          r_valid[i]      <= 1'b0;
          r_addr_valid[i] <= 1'b0;
        end
        if (w_drain_fire && (w_head_idx == IDX_W'(i))) begin
          r_valid[i] <= 1'b0;
        end
      end
    end
  end

  // Entry payload: rob id at alloc, address/mask/data at AGU fill; qualified by status bits.
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (w_alloc_fire && (w_tail_idx == IDX_W'(i))) begin
        r_rob_id[i] <= i_alloc_rob_id;
      end
      if (w_agu_hit[i]) begin
        r_addr[i]  <= i_agu_addr;
        r_mask[i]  <= i_agu_mask;
        r_wdata[i] <= i_agu_wdata;
      end
    end
  end

endmodule
